// File: rtl/obi_arb_pkg.sv
// Shared types and defaults for the two-port OBI arbiter and its route FIFO.
package obi_arb_pkg;
    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    localparam int unsigned DEFAULT_DEPTH = 4;
endpackage

// File: rtl/obi_port_arbiter_if.sv
// Bundle of the instruction, data and memory OBI signals seen by the arbiter.
interface obi_port_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    // Handshakes: a request is accepted in the cycle where req and gnt are both
    // high; each accepted request is answered by exactly one rvalid, in order.
    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o, err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o, err_o
    );
endinterface

// File: rtl/obi_route_fifo.sv
// In-order FIFO of source IDs; one entry per granted-but-unanswered request.
module obi_route_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  src_e                     src_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output src_e                     head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    src_e          mem_q [DEPTH];
    src_e          mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wptr_q] = src_i;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + AW'(1);
        end
        // Power-of-two depth lets the pointers wrap naturally.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SRC_INSTR;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];
endmodule

// File: rtl/obi_port_arbiter.sv
// Round-robin arbiter merging an instruction and a data OBI port onto one
// memory port, with in-order response routing and a sticky protocol error.
module obi_port_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_be_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);
    src_e                  sel;
    src_e                  lock_src_q, lock_src_d;
    src_e                  last_gnt_q, last_gnt_d;
    logic                  lock_q, lock_d;
    logic                  err_q, err_d;
    logic                  sel_req;
    logic                  handshake;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    src_e                  fifo_head;

    // A stalled request pins the selection so the bus payload cannot switch.
    always_comb begin
        sel = SRC_INSTR;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_gnt_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end else if (data_req_i) begin
            sel = SRC_DATA;
        end
    end

    assign sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    assign mem_req_o = rst_ni && sel_req && !fifo_full;
    assign handshake = mem_req_o && mem_gnt_i;
    assign pop       = mem_rvalid_i && !fifo_empty;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (rst_ni) begin
            if (sel == SRC_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_wdata_o = data_wdata_i;
                mem_be_o    = data_be_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_be_o    = 4'hF;
            end
        end
    end

    assign instr_gnt_o    = handshake && (sel == SRC_INSTR);
    assign data_gnt_o     = handshake && (sel == SRC_DATA);
    assign instr_rvalid_o = pop && (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = pop && (fifo_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = err_q;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q | (mem_rvalid_i && fifo_empty);
        if (handshake) begin
            lock_d     = 1'b0;
            last_gnt_d = sel;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            last_gnt_q <= SRC_INSTR;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
        end
    end

    obi_route_fifo #(
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .src_i   (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    count_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= ($clog2(DEPTH)+1)'(DEPTH));
endmodule

// File: tb/tb_obi_port_arbiter.sv
// Directed and randomized checks of obi_port_arbiter against a queue-based model.
module tb_obi_port_arbiter;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    obi_port_arbiter_if bus ();

    obi_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (bus.instr_req_i),
        .instr_addr_i   (bus.instr_addr_i),
        .instr_gnt_o    (bus.instr_gnt_o),
        .instr_rvalid_o (bus.instr_rvalid_o),
        .instr_rdata_o  (bus.instr_rdata_o),
        .data_req_i     (bus.data_req_i),
        .data_addr_i    (bus.data_addr_i),
        .data_we_i      (bus.data_we_i),
        .data_wdata_i   (bus.data_wdata_i),
        .data_be_i      (bus.data_be_i),
        .data_gnt_o     (bus.data_gnt_o),
        .data_rvalid_o  (bus.data_rvalid_o),
        .data_rdata_o   (bus.data_rdata_o),
        .mem_req_o      (bus.mem_req_o),
        .mem_addr_o     (bus.mem_addr_o),
        .mem_we_o       (bus.mem_we_o),
        .mem_wdata_o    (bus.mem_wdata_o),
        .mem_be_o       (bus.mem_be_o),
        .mem_gnt_i      (bus.mem_gnt_i),
        .mem_rvalid_i   (bus.mem_rvalid_i),
        .mem_rdata_i    (bus.mem_rdata_i),
        .err_o          (bus.err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Outstanding requests are a plain queue of source numbers (0=instr, 1=data).
    int route_q[$];
    int m_last;
    bit m_lock;
    int m_lock_src;
    bit m_err;

    int          e_sel;
    bit          e_mreq, e_igtn, e_dgnt, e_irv, e_drv, e_pop;
    logic [31:0] e_addr, e_wdata;
    bit          e_we;
    logic [3:0]  e_be;

    task automatic model_reset();
        route_q.delete();
        m_last = 0;
        m_lock = 0;
        m_lock_src = 0;
        m_err = 0;
    endtask

    task automatic model_eval();
        bit req;
        if (m_lock) e_sel = m_lock_src;
        else if (bus.instr_req_i && bus.data_req_i) e_sel = 1 - m_last;
        else e_sel = bus.data_req_i ? 1 : 0;
        req    = (e_sel == 1) ? bus.data_req_i : bus.instr_req_i;
        e_mreq = req && (route_q.size() < DEPTH);
        e_igtn = e_mreq && bus.mem_gnt_i && (e_sel == 0);
        e_dgnt = e_mreq && bus.mem_gnt_i && (e_sel == 1);
        e_pop  = bus.mem_rvalid_i && (route_q.size() > 0);
        e_irv  = e_pop && (route_q[0] == 0);
        e_drv  = e_pop && (route_q[0] == 1);
        e_addr  = (e_sel == 1) ? bus.data_addr_i  : bus.instr_addr_i;
        e_we    = (e_sel == 1) ? bus.data_we_i    : 1'b0;
        e_wdata = (e_sel == 1) ? bus.data_wdata_i : 32'h0;
        e_be    = (e_sel == 1) ? bus.data_be_i    : 4'hF;
    endtask

    task automatic model_update();
        if (bus.mem_rvalid_i && route_q.size() == 0) m_err = 1;
        if (e_pop) void'(route_q.pop_front());
        if (e_mreq && bus.mem_gnt_i) begin
            route_q.push_back(e_sel);
            m_last = e_sel;
            m_lock = 0;
        end else if (e_mreq) begin
            m_lock = 1;
            m_lock_src = e_sel;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_we_i    = 1'b0;
        bus.data_wdata_i = '0;
        bus.data_be_i    = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.instr_req_i  = 1'b1;
        bus.data_req_i   = 1'b1;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        bus.data_addr_i  = 32'h55;
        #2;
        checks++;
        if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
             bus.data_rvalid_o, bus.err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {bus.mem_req_o, bus.instr_gnt_o,
                     bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o});
        end
        checks++;
        if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o} !== 69'h0) begin
            errors++;
            $display("FAIL reset_payload got %h/%h/%h/%b exp zeros", bus.mem_addr_o,
                     bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o);
        end
        checks++;
        if (bus.instr_rdata_o !== 32'h1234_5678 || bus.data_rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h exp 12345678", bus.instr_rdata_o, bus.data_rdata_o);
        end
        repeat (2) @(posedge clk);
        #1 drive_idle();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_err_after got %b exp 0", bus.err_o);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        do_reset();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h100;
        bus.data_req_i  = 1'b1; bus.data_addr_i  = 32'h200;
        bus.mem_gnt_i   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.data_gnt_o, bus.instr_gnt_o} !== ((c == 0) ? 2'b10 : 2'b01) ||
                bus.mem_addr_o !== ((c == 0) ? 32'h200 : 32'h100)) begin
                errors++;
                $display("FAIL contention_c%0d got gnt=%b addr=%h", c,
                         {bus.data_gnt_o, bus.instr_gnt_o}, bus.mem_addr_o);
            end
            next_cycle();
        end
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hAAAA_0000 + c;
            @(negedge clk);
            checks++;
            if ({bus.data_rvalid_o, bus.instr_rvalid_o} !== ((c == 0) ? 2'b10 : 2'b01) ||
                bus.data_rdata_o !== 32'hAAAA_0000 + c) begin
                errors++;
                $display("FAIL contention_resp%0d got rv=%b rdata=%h", c,
                         {bus.data_rvalid_o, bus.instr_rvalid_o}, bus.data_rdata_o);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_lock();
        do_reset();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h40;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.data_req_i = 1'b1; bus.data_addr_i = 32'h80;
                bus.data_we_i  = 1'b1; bus.data_be_i   = 4'h1;
            end
            @(negedge clk);
            checks++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.mem_we_o !== 1'b0 ||
                bus.mem_be_o !== 4'hF || bus.instr_gnt_o !== 1'b0 || bus.data_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold_c%0d got req=%b addr=%h we=%b be=%h", c,
                         bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o);
            end
            next_cycle();
        end
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0 || bus.mem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL lock_release got igtn=%b dgnt=%b addr=%h exp 1 0 40",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.data_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h80 || bus.mem_we_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_next_data got dgnt=%b addr=%h we=%b exp 1 80 1",
                     bus.data_gnt_o, bus.mem_addr_o, bus.mem_we_o);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_depth_limit();
        do_reset();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h300; bus.mem_gnt_i = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_gnt_o !== 1'b1) begin
                errors++;
                $display("FAIL depth_fill_c%0d got gnt=%b exp 1", c, bus.instr_gnt_o);
            end
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.instr_gnt_o !== 1'b0 || bus.instr_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL depth_full got req=%b gnt=%b rvalid=%b exp 0 0 1",
                     bus.mem_req_o, bus.instr_gnt_o, bus.instr_rvalid_o);
        end
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.instr_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL depth_reopen got req=%b gnt=%b exp 1 1", bus.mem_req_o, bus.instr_gnt_o);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_err_sticky();
        do_reset();
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_drop got rv=%b%b err=%b exp 00 0",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o);
        end
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.err_o !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky_c%0d got %b exp 1", c, bus.err_o);
            end
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", bus.err_o);
        end
        next_cycle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write();
        do_reset();
        bus.data_req_i   = 1'b1; bus.data_addr_i = 32'h10; bus.data_we_i = 1'b1;
        bus.data_be_i    = 4'b0011; bus.data_wdata_i = 32'hDEAD_BEEF; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'b0011 ||
            bus.mem_wdata_o !== 32'hDEAD_BEEF || bus.mem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL write_payload got gnt=%b we=%b be=%b wdata=%h addr=%h", bus.data_gnt_o,
                     bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o);
        end
        next_cycle();
        bus.data_req_i = 1'b0; bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h20;
        @(negedge clk);
        checks++;
        if (bus.instr_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_be_o !== 4'hF ||
            bus.mem_wdata_o !== 32'h0 || bus.mem_addr_o !== 32'h20) begin
            errors++;
            $display("FAIL instr_payload got gnt=%b we=%b be=%b wdata=%h addr=%h", bus.instr_gnt_o,
                     bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.instr_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        repeat (2) next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.instr_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out got req=%b gnt=%b exp 0 0", bus.mem_req_o, bus.instr_gnt_o);
        end
        next_cycle();
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop got rv=%b%b exp 00", bus.instr_rvalid_o, bus.data_rvalid_o);
        end
        next_cycle();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_err got %b exp 1", bus.err_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit exp_data;
        do_reset();
        bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.mem_rvalid_i = (c > 0);
            exp_data = (c % 2 == 0);
            @(negedge clk);
            checks++;
            if ({bus.data_gnt_o, bus.instr_gnt_o} !== (exp_data ? 2'b10 : 2'b01) ||
                (c > 0 && {bus.data_rvalid_o, bus.instr_rvalid_o} !== (exp_data ? 2'b01 : 2'b10))) begin
                errors++;
                $display("FAIL b2b_c%0d got gnt=%b rv=%b", c, {bus.data_gnt_o, bus.instr_gnt_o},
                         {bus.data_rvalid_o, bus.instr_rvalid_o});
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.instr_req_i  = ($urandom_range(2, 0) != 0);
            bus.instr_addr_i = $urandom;
            bus.data_req_i   = ($urandom_range(2, 0) != 0);
            bus.data_addr_i  = $urandom;
            bus.data_we_i    = $urandom_range(1, 0);
            bus.data_wdata_i = $urandom;
            bus.data_be_i    = 4'($urandom_range(15, 0));
            bus.mem_gnt_i    = $urandom_range(1, 0);
            bus.mem_rvalid_i = ($urandom_range(2, 0) == 0);
            bus.mem_rdata_i  = $urandom;
            @(negedge clk);
            model_eval();
            checks++;
            if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o,
                 bus.data_rvalid_o, bus.err_o} !== {e_mreq, e_igtn, e_dgnt, e_irv, e_drv, m_err}) begin
                errors++;
                $display("FAIL rand_ctrl_c%0d got %b exp %b", c, {bus.mem_req_o, bus.instr_gnt_o,
                         bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o},
                         {e_mreq, e_igtn, e_dgnt, e_irv, e_drv, m_err});
            end
            checks++;
            if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, bus.mem_be_o} !==
                {e_addr, e_we, e_wdata, e_be}) begin
                errors++;
                $display("FAIL rand_payload_c%0d got %h/%b/%h/%h exp %h/%b/%h/%h", c, bus.mem_addr_o,
                         bus.mem_we_o, bus.mem_wdata_o, bus.mem_be_o, e_addr, e_we, e_wdata, e_be);
            end
            checks++;
            if (bus.instr_rdata_o !== bus.mem_rdata_i || bus.data_rdata_o !== bus.mem_rdata_i) begin
                errors++;
                $display("FAIL rand_rdata_c%0d got %h/%h exp %h", c, bus.instr_rdata_o,
                         bus.data_rdata_o, bus.mem_rdata_i);
            end
            @(posedge clk);
            model_update();
            #1;
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_contention();
        test_lock();
        test_depth_limit();
        test_err_sticky();
        test_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obi_port_arbiter.md
OBI_PORT_ARBITER -- requirements
Module: obi_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding granted-but-unanswered transactions (power of two, >=2).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  instruction request
- instr_addr_i  in  32  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction read valid
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  data request
- data_addr_i  in  32  data address
- data_we_i  in  1  data write enable
- data_wdata_i  in  32  data write data
- data_be_i  in  4  data byte enable
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data read valid
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  32  memory write data
- mem_be_o  out  4  memory byte enable
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- err_o  out  1  sticky protocol error

Function
REQ-003 SHALL select one source per cycle combinationally; instr source drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-004 SHALL arbitrate round-robin: on contention the source not granted last wins; last_gnt register updates only on mem_req_o && mem_gnt_i.
REQ-005 SHALL lock the selection once mem_req_o is asserted without mem_gnt_i; lock holds until gnt, so mem_addr/we/wdata/be stay stable even if the other source requests.
REQ-006 SHALL drive mem_req_o = selected req && (count < DEPTH); when count==DEPTH, mem_req_o=0 and both gnts 0, even if mem_rvalid_i pops in that cycle.
REQ-007 SHALL assert instr_gnt_o/data_gnt_o combinationally = mem_gnt_i && mem_req_o && (selected == that source); zero added latency.
REQ-008 SHALL push the granted source ID into an in-order route FIFO on each mem handshake; simultaneous push and pop SHALL leave count unchanged.
REQ-009 SHALL route mem_rvalid_i combinationally to the rvalid of the FIFO head source and pop; mem_rdata_i SHALL drive both rdata outputs unconditionally.
REQ-010 SHALL, on mem_rvalid_i with empty FIFO, drop the response (no rvalid out) and set err_o, held until reset.
REQ-011 SHALL support back-to-back handshakes every cycle, alternating sources when both request continuously.
REQ-012 SHALL let a source with req held and no contention be granted on consecutive cycles.

Reset
REQ-013 SHALL on rst_ni low: FIFO empty, count=0, lock cleared, last_gnt=INSTR (data wins first tie), err_o=0; all outputs 0 except data_rdata_o/instr_rdata_o, which follow mem_rdata_i.
REQ-014 SHALL on reset mid-operation discard outstanding IDs; responses arriving after reset SHALL set err_o.

Structure
REQ-015 SHALL place typedef src_e {SRC_INSTR, SRC_DATA} and the default DEPTH constant in package obi_arb_pkg.
REQ-016 SHALL implement the route FIFO as sub-module obi_route_fifo (parameterised depth, push/pop/full/empty/count, head output).

Verification
REQ-017 Both req at 0x100/0x200, mem_gnt_i=1 after reset -> data granted cycle 0, instr cycle 1; rvalids return data then instr in order.
REQ-018 instr req 0x40, mem_gnt_i=0 for 3 cycles, data req asserted cycle 1 -> mem_addr_o stays 0x40 until gnt; data granted next.
REQ-019 DEPTH=4, 4 grants, no rvalid -> 5th req sees mem_req_o=0; one mem_rvalid_i -> mem_req_o=1 next cycle.
REQ-020 mem_rvalid_i pulse with empty FIFO -> no rvalid out, err_o=1 sticky until rst_ni low.
REQ-021 Data write addr 0x10 be=4'b0011 wdata 0xDEADBEEF -> mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF during handshake.
REQ-022 rst_ni low with 2 outstanding -> outputs cleared; subsequent mem_rvalid_i sets err_o.
